// File: rtl/arm_mc_ctrl.sv
// Main control FSM for the multi-cycle ARMv7-subset CPU: sequences fetch, decode,
// execute, memory and writeback for one instruction at a time.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | load IR, PC <= PC+4
// DECODE | latch A/B, check condition, dispatch on class
// EX_DP  | data-processing ALU op into C
// WB_DP  | DP writeback / flags update
// EX_MEM | address calculation into C
// MEM_RD | synchronous RAM read latency
// WB_LD  | load data writeback
// MEM_WR | store to data memory
// BRANCH | PC <= branch target, optional link write
module arm_mc_ctrl #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic [31:0]     IR,
  input  logic            flag,
  output logic            Write_PC,
  output logic [1:0]      PC_s,
  output logic            Write_IR,
  output logic            Write_A,
  output logic            Write_B,
  output logic            Write_C,
  output logic [3:0]      ALU_OP,
  output logic            imm_sel,
  output logic            Write_Reg,
  output logic [1:0]      rf_wsel,
  output logic            link_sel,
  output logic            Write_CPSR,
  output logic            Mem_Write,
  output logic            instr_done,
  output logic            undef,
  output logic [ST_W-1:0] state
);

  localparam logic [ST_W-1:0] S_IDLE   = ST_W'(0);
  localparam logic [ST_W-1:0] S_FETCH  = ST_W'(1);
  localparam logic [ST_W-1:0] S_DECODE = ST_W'(2);
  localparam logic [ST_W-1:0] S_EX_DP  = ST_W'(3);
  localparam logic [ST_W-1:0] S_WB_DP  = ST_W'(4);
  localparam logic [ST_W-1:0] S_EX_MEM = ST_W'(5);
  localparam logic [ST_W-1:0] S_MEM_RD = ST_W'(6);
  localparam logic [ST_W-1:0] S_WB_LD  = ST_W'(7);
  localparam logic [ST_W-1:0] S_MEM_WR = ST_W'(8);
  localparam logic [ST_W-1:0] S_BRANCH = ST_W'(9);

  logic [ST_W-1:0] state_nxt;
  logic            dp_test;
  logic            class_ok;

  // TST/TEQ/CMP/CMN only update flags
  assign dp_test  = (IR[24:23] == 2'b10);
  assign class_ok = (IR[27:26] == 2'b00) || (IR[27:25] == 3'b010) || (IR[27:25] == 3'b101);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_DECODE: begin
        if (flag) begin
          case (IR[27:25])
            3'b000, 3'b001: state_nxt = S_EX_DP;
            3'b010:         state_nxt = S_EX_MEM;
            3'b101:         state_nxt = S_BRANCH;
            default:        state_nxt = S_FETCH;
          endcase
        end
      end
      S_FETCH:  state_nxt = S_DECODE;
      S_EX_DP:  state_nxt = S_WB_DP;
      S_EX_MEM: state_nxt = IR[20] ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: state_nxt = S_WB_LD;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    Write_PC   = 1'b0;
    PC_s       = 2'b00;
    Write_IR   = 1'b0;
    Write_A    = 1'b0;
    Write_B    = 1'b0;
    Write_C    = 1'b0;
    ALU_OP     = 4'b0000;
    imm_sel    = 1'b0;
    Write_Reg  = 1'b0;
    rf_wsel    = 2'b00;
    link_sel   = 1'b0;
    Write_CPSR = 1'b0;
    Mem_Write  = 1'b0;
    instr_done = 1'b0;
    undef      = 1'b0;
    case (state)
      S_FETCH: begin
        Write_IR = 1'b1;
        Write_PC = 1'b1;
      end
      S_DECODE: begin
        Write_A = 1'b1;
        Write_B = 1'b1;
        undef   = flag & ~class_ok;
      end
      S_EX_DP: begin
        Write_C = 1'b1;
        ALU_OP  = IR[24:21];
        imm_sel = IR[25];
      end
      S_WB_DP: begin
        instr_done = 1'b1;
        Write_Reg  = ~dp_test;
        Write_CPSR = IR[20] | dp_test;
      end
      S_EX_MEM: begin
        Write_C = 1'b1;
        imm_sel = 1'b1;
        ALU_OP  = IR[23] ? 4'b0100 : 4'b0010;
      end
      S_WB_LD: begin
        Write_Reg  = 1'b1;
        rf_wsel    = 2'b01;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        Mem_Write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        Write_PC   = 1'b1;
        PC_s       = 2'b01;
        instr_done = 1'b1;
        if (IR[24]) begin
          Write_Reg = 1'b1;
          rf_wsel   = 2'b10;
          link_sel  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Bench for arm_mc_ctrl: directed test-plan instructions plus random instructions,
// checked cycle by cycle against an instruction-level reference model.
module tb_arm_mc_ctrl;

  typedef struct packed {
    logic       wpc;
    logic [1:0] pcs;
    logic       wir, wa, wb, wc;
    logic [3:0] alu;
    logic       imm, wreg;
    logic [1:0] rfw;
    logic       link, cpsr, memw, done, und;
  } out_t;

  logic        clk = 0;
  logic        Rst = 1;
  logic [31:0] IR = '0;
  logic        flag = 0;
  logic        Write_PC, Write_IR, Write_A, Write_B, Write_C, imm_sel, Write_Reg;
  logic        link_sel, Write_CPSR, Mem_Write, instr_done, undef;
  logic [1:0]  PC_s, rf_wsel;
  logic [3:0]  ALU_OP, state;
  out_t        dut_o;

  int checks = 0;
  int errors = 0;

  int   m_st[$];
  out_t m_out[$];

  arm_mc_ctrl #(.ST_W(4)) dut (
    .clk(clk), .Rst(Rst), .IR(IR), .flag(flag),
    .Write_PC(Write_PC), .PC_s(PC_s), .Write_IR(Write_IR), .Write_A(Write_A),
    .Write_B(Write_B), .Write_C(Write_C), .ALU_OP(ALU_OP), .imm_sel(imm_sel),
    .Write_Reg(Write_Reg), .rf_wsel(rf_wsel), .link_sel(link_sel),
    .Write_CPSR(Write_CPSR), .Mem_Write(Mem_Write), .instr_done(instr_done),
    .undef(undef), .state(state)
  );

  always #5 clk = ~clk;

  assign dut_o = {Write_PC, PC_s, Write_IR, Write_A, Write_B, Write_C, ALU_OP, imm_sel,
                  Write_Reg, rf_wsel, link_sel, Write_CPSR, Mem_Write, instr_done, undef};

  function automatic void push(input int st, input out_t o);
    m_st.push_back(st);
    m_out.push_back(o);
  endfunction

  // Expected per-cycle state/outputs from FETCH entry up to the next FETCH entry.
  function automatic void model(input logic [31:0] ir, input logic f);
    out_t o;
    int   opc;
    int   cls;
    bit   is_test;
    opc = int'(ir[24:21]);
    cls = int'(ir[27:25]);
    m_st.delete();
    m_out.delete();
    o = '0; o.wpc = 1; o.wir = 1;
    push(1, o);
    o = '0; o.wa = 1; o.wb = 1;
    if (!f) begin
      push(2, o);
      return;
    end
    if (cls == 0 || cls == 1) begin
      push(2, o);
      o = '0; o.wc = 1; o.alu = 4'(opc); o.imm = (cls == 1);
      push(3, o);
      is_test = (opc >= 8 && opc <= 11);
      o = '0; o.done = 1; o.wreg = !is_test; o.cpsr = is_test || ir[20];
      push(4, o);
    end else if (cls == 2) begin
      push(2, o);
      o = '0; o.wc = 1; o.imm = 1; o.alu = ir[23] ? 4'd4 : 4'd2;
      push(5, o);
      if (ir[20]) begin
        o = '0;
        push(6, o);
        o = '0; o.wreg = 1; o.rfw = 2'd1; o.done = 1;
        push(7, o);
      end else begin
        o = '0; o.memw = 1; o.done = 1;
        push(8, o);
      end
    end else if (cls == 5) begin
      push(2, o);
      o = '0; o.wpc = 1; o.pcs = 2'd1; o.done = 1;
      if (ir[24]) begin
        o.wreg = 1; o.rfw = 2'd2; o.link = 1;
      end
      push(9, o);
    end else begin
      o.und = 1;
      push(2, o);
    end
  endfunction

  // Called at a falling edge with the DUT in FETCH; returns at the next FETCH's falling edge.
  task automatic run_instr(input logic [31:0] ir, input logic f);
    model(ir, f);
    IR   = ir;
    flag = f;
    for (int i = 0; i < m_st.size(); i++) begin
      if (i >= 2) flag = 1'($urandom);
      #1;
      checks++;
      if (int'(state) !== m_st[i]) begin
        errors++;
        $display("FAIL state ir=%h cyc=%0d got=%0d exp=%0d", ir, i, state, m_st[i]);
      end
      checks++;
      if (dut_o !== m_out[i]) begin
        errors++;
        $display("FAIL outputs ir=%h st=%0d got=%h exp=%h", ir, m_st[i], dut_o, m_out[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    Rst  = 1;
    IR   = $urandom;
    flag = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (dut_o !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", dut_o); end
    @(negedge clk);
    Rst = 0;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL idle_after_release got=%0d exp=0", state); end
    @(negedge clk);
  endtask

  task automatic test_dp();
    run_instr(32'hE2811005, 1'b1);
    run_instr(32'hE1500002, 1'b1);
  endtask

  task automatic test_mem();
    run_instr(32'hE5912004, 1'b1);
    run_instr(32'hE5012004, 1'b1);
  endtask

  task automatic test_branch();
    run_instr(32'hEB000010, 1'b1);
    run_instr(32'hEA000010, 1'b1);
  endtask

  task automatic test_skip_undef();
    run_instr(32'h0A000003, 1'b0);
    run_instr(32'hEC000000, 1'b1);
  endtask

  task automatic test_reset_mid_store();
    IR   = 32'hE5012004;
    flag = 1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd8 || Mem_Write !== 1'b1) begin
      errors++;
      $display("FAIL reach_mem_wr state=%0d memw=%b exp state=8 memw=1", state, Mem_Write);
    end
    #1 Rst = 1;
    #1;
    checks++;
    if (Mem_Write !== 1'b0) begin errors++; $display("FAIL async_memw got=%b exp=0", Mem_Write); end
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", state); end
    @(negedge clk);
    Rst = 0;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL restart_idle got=%0d exp=0", state); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] ir;
    logic        f;
    for (int n = 0; n < 300; n++) begin
      ir = $urandom;
      f  = ($urandom_range(0, 3) != 0);
      run_instr(ir, f);
    end
  endtask

  initial begin
    test_reset();
    test_dp();
    test_mem();
    test_branch();
    test_skip_undef();
    test_reset_mid_store();
    test_random();
    test_dp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
